// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests from the PC register,
// buffers returned words with their PCs and presents them to decode.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal fetch; responses are written into the output FIFO
// DRAIN | drop_cnt responses from before a flush are still in flight;
//       | each one is discarded, returns to RUN when drop_cnt hits 0
module instr_fetch_unit #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_step_o,
    input  logic            flush_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    input  logic            if_ready_i
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(BUF_DEPTH);
    localparam logic [CW:0]   ONE_W      = (CW+1)'(1);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [PW-1:0] ONE_P      = PW'(1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   outst_cnt;
    logic [CW-1:0]   fifo_cnt;
    logic [CW-1:0]   drop_cnt, drop_nxt;
    logic [CW:0]     credit_used;
    logic [CW:0]     inflight;
    logic [PW-1:0]   pcq_wr, pcq_rd;
    logic [PW-1:0]   fifo_wr, fifo_rd;
    logic [XLEN-1:0] pcq_mem    [BUF_DEPTH];
    logic [XLEN-1:0] fifo_instr [BUF_DEPTH];
    logic [XLEN-1:0] fifo_pc    [BUF_DEPTH];
    logic            accept;
    logic            rsp_take;
    logic            deq;

    // Credit uses registered counts only, so a dequeue never opens a
    // request slot in the same cycle (no if_ready -> req_valid path).
    assign credit_used = {1'b0, outst_cnt} + {1'b0, fifo_cnt};
    assign inflight    = {1'b0, outst_cnt} + {1'b0, drop_cnt};

    assign imem_req_valid_o = rst && (state == RUN) && !flush_i &&
                              (credit_used < CREDIT_MAX);
    assign imem_req_addr_o  = rst ? pc_i : '0;
    assign accept           = imem_req_valid_o && imem_req_ready_i;
    assign pc_step_o        = accept;

    assign rsp_take   = imem_rsp_valid_i && (state == RUN) && !flush_i;
    assign if_valid_o = (fifo_cnt != '0);
    assign deq        = if_valid_o && if_ready_i;
    assign if_instr_o = if_valid_o ? fifo_instr[fifo_rd] : '0;
    assign if_pc_o    = if_valid_o ? fifo_pc[fifo_rd] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    // A flush folds everything still owed by memory (outstanding plus any
    // residual drops) into drop_cnt, minus a response landing this cycle.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        if (flush_i) begin
            if (imem_rsp_valid_i && (inflight != '0)) begin
                drop_nxt = CW'(inflight - ONE_W);
            end else begin
                drop_nxt = CW'(inflight);
            end
            state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
        end else if (state == DRAIN) begin
            if (imem_rsp_valid_i && (drop_cnt != '0)) begin
                drop_nxt = drop_cnt - ONE_C;
            end
            state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst_cnt <= '0;
            fifo_cnt  <= '0;
            pcq_wr    <= '0;
            pcq_rd    <= '0;
            fifo_wr   <= '0;
            fifo_rd   <= '0;
        end else if (flush_i) begin
            outst_cnt <= '0;
            fifo_cnt  <= '0;
            pcq_wr    <= '0;
            pcq_rd    <= '0;
            fifo_wr   <= '0;
            fifo_rd   <= '0;
        end else begin
            if (accept) begin
                pcq_wr <= pcq_wr + ONE_P;
            end
            if (rsp_take) begin
                pcq_rd  <= pcq_rd + ONE_P;
                fifo_wr <= fifo_wr + ONE_P;
            end
            if (deq) begin
                fifo_rd <= fifo_rd + ONE_P;
            end
            outst_cnt <= outst_cnt + CW'(accept) - CW'(rsp_take);
            fifo_cnt  <= fifo_cnt + CW'(rsp_take) - CW'(deq);
        end
    end

    // Storage needs no reset: entries are only read behind valid counts.
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_wr] <= pc_i;
        end
        if (rsp_take) begin
            fifo_instr[fifo_wr] <= imem_rsp_data_i;
            fifo_pc[fifo_wr]    <= pcq_mem[pcq_rd];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register and latency-programmable imem model,
// scoreboard of accepted fetches, table-driven phases plus corner sequences.
module tb_instr_fetch_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [XLEN-1:0] pc_i = '0;
    logic            pc_step_o;
    logic            flush_i = 1'b0;
    logic            imem_req_valid_o;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_req_ready_i = 1'b0;
    logic            imem_rsp_valid_i = 1'b0;
    logic [XLEN-1:0] imem_rsp_data_i = '0;
    logic            if_valid_o;
    logic [XLEN-1:0] if_instr_o;
    logic [XLEN-1:0] if_pc_o;
    logic            if_ready_i = 1'b0;

    instr_fetch_unit #(.XLEN(XLEN), .BUF_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .pc_step_o        (pc_step_o),
        .flush_i          (flush_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_valid_o       (if_valid_o),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .if_ready_i       (if_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int step_cnt = 0;
    int out_cnt  = 0;
    logic [XLEN-1:0] last_out_pc = '0;
    logic [XLEN-1:0] pc_reset_val = '0;
    logic [XLEN-1:0] flush_pc = '0;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [XLEN-1:0] addr;
        int              due;
    } mreq_t;
    mreq_t mq[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PC register + imem model. Runs 1 time unit behind the main driver.
    initial begin
        logic            acc, rst_seen, flush_seen, live;
        logic [XLEN-1:0] a;
        int              cyc;
        cyc  = 0;
        live = 1'b0;
        forever begin
            @(negedge clk);
            rst_seen   = rst;
            flush_seen = flush_i;
            acc        = imem_req_valid_o & imem_req_ready_i;
            a          = imem_req_addr_o;
            @(posedge clk);
            #2;
            cyc++;
            if (!rst_seen) begin
                mq.delete();
                live = 1'b0;
            end else begin
                if (live && mq.size() > 0) void'(mq.pop_front());
                if (acc) mq.push_back('{addr: a, due: cyc - 1 + lat});
            end
            if (!rst) begin
                pc_i             = $urandom;
                imem_rsp_valid_i = 1'($urandom);
                imem_rsp_data_i  = $urandom;
                live             = 1'b0;
            end else begin
                if (!rst_seen)       pc_i = pc_reset_val;
                else if (flush_seen) pc_i = flush_pc;
                else if (acc)        pc_i = pc_i + 32'd4;
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = 32'h1000 + mq[0].addr;
                    live             = 1'b1;
                end else begin
                    imem_rsp_valid_i = 1'b0;
                    imem_rsp_data_i  = '0;
                    live             = 1'b0;
                end
            end
        end
    end

    // Scoreboard: push on accept, pop/compare on decode handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
            end else begin
                if (if_valid_o && if_ready_i) begin
                    out_cnt++;
                    last_out_pc = if_pc_o;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got pc %h, expected no output", if_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_pc", if_pc_o, e.pc);
                        check("out_instr", if_instr_o, e.instr);
                    end
                end
                if (flush_i) exp_q.delete();
                if (imem_req_valid_o) check("req_addr", imem_req_addr_o, pc_i);
                check("pc_step", 32'(pc_step_o), 32'(imem_req_valid_o & imem_req_ready_i));
                if (pc_step_o) begin
                    step_cnt++;
                    exp_q.push_back('{pc: pc_i, instr: 32'h1000 + pc_i});
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, 32'(|{pc_step_o, imem_req_valid_o, imem_req_addr_o,
                          if_valid_o, if_instr_o, if_pc_o}), 32'd0);
    endtask

    task automatic do_reset(input logic [XLEN-1:0] pc0);
        pc_reset_val = pc0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush_i          = 1'($urandom);
            imem_req_ready_i = 1'($urandom);
            if_ready_i       = 1'($urandom);
            #1;
            check_all_zero("rst_outputs");
            tick();
        end
        flush_i          = 1'b0;
        imem_req_ready_i = 1'b1;
        if_ready_i       = 1'b0;
        rst              = 1'b1;
    endtask

    task automatic wait_first_out(input string name, input logic [XLEN-1:0] exp_pc, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (if_valid_o && if_ready_i) begin
                seen = 1'b1;
                check(name, if_pc_o, exp_pc);
            end
            tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got no output, expected pc %h", name, exp_pc);
        end
    endtask

    typedef struct {
        int   lat;
        bit   mem_rdy;
        bit   dec_rdy;
        int   cycles;
        int   exp_steps;
        int   exp_outs;
        logic [XLEN-1:0] exp_last_pc;
        bit   exp_req_end;
    } vec_t;

    initial begin
        vec_t vt[6];
        int   s0, o0;

        vt[0] = '{1, 1'b1, 1'b1, 20, 20, 18, 32'h44, 1'b1};
        vt[1] = '{2, 1'b1, 1'b1, 20, 20, 17, 32'h40, 1'b1};
        vt[2] = '{1, 1'b1, 1'b0, 20,  4,  0, 32'h0,  1'b0};
        vt[3] = '{3, 1'b1, 1'b0, 20,  4,  0, 32'h0,  1'b0};
        vt[4] = '{2, 1'b1, 1'b0, 20,  4,  0, 32'h0,  1'b0};
        vt[5] = '{1, 1'b0, 1'b1, 10,  0,  0, 32'h0,  1'b1};

        // Reset with random inputs, first request after release
        do_reset(32'h0);
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("first_req_addr", imem_req_addr_o, 32'h0);
        tick();

        for (int v = 0; v < 6; v++) begin
            do_reset(32'h0);
            lat              = vt[v].lat;
            imem_req_ready_i = vt[v].mem_rdy;
            if_ready_i       = vt[v].dec_rdy;
            s0 = step_cnt;
            o0 = out_cnt;
            repeat (vt[v].cycles) tick();
            check($sformatf("vec%0d_steps", v), 32'(step_cnt - s0), 32'(vt[v].exp_steps));
            check($sformatf("vec%0d_outs", v), 32'(out_cnt - o0), 32'(vt[v].exp_outs));
            if (vt[v].exp_outs > 0)
                check($sformatf("vec%0d_last_pc", v), last_out_pc, vt[v].exp_last_pc);
            @(negedge clk);
            check($sformatf("vec%0d_req_valid_end", v), 32'(imem_req_valid_o), 32'(vt[v].exp_req_end));
            tick();
        end

        // Buffer full with decode stalled, then drain and resume at 0x10
        do_reset(32'h0);
        lat = 1;
        repeat (12) tick();
        @(negedge clk);
        check("full_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("full_pc_step", 32'(pc_step_o), 32'd0);
        tick();
        if_ready_i = 1'b1;
        o0 = out_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("resume_step", 32'(pc_step_o), 32'd1);
                check("resume_addr", imem_req_addr_o, 32'h10);
            end
            tick();
        end
        check("resume_outs", 32'(out_cnt - o0), 32'd6);
        check("resume_last_pc", last_out_pc, 32'h14);

        // Memory back-pressure holds the address
        do_reset(32'h20);
        lat              = 1;
        imem_req_ready_i = 1'b0;
        if_ready_i       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_valid", 32'(imem_req_valid_o), 32'd1);
            check("stall_addr", imem_req_addr_o, 32'h20);
            check("stall_no_step", 32'(pc_step_o), 32'd0);
            tick();
        end
        imem_req_ready_i = 1'b1;
        @(negedge clk);
        check("stall_release_step", 32'(pc_step_o), 32'd1);
        tick();
        imem_req_ready_i = 1'b0;
        wait_first_out("stall_out_pc", 32'h20, 6);

        // Flush with two in flight (0x40, 0x44) and 0x3C buffered
        do_reset(32'h3C);
        lat      = 3;
        flush_pc = 32'h100;
        repeat (3) tick();
        imem_req_ready_i = 1'b0;
        @(negedge clk);
        check("pre_flush_valid", 32'(if_valid_o), 32'd0);
        tick();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_cycle_valid", 32'(if_valid_o), 32'd1);
        check("flush_cycle_pc", if_pc_o, 32'h3C);
        check("flush_cycle_no_req", 32'(imem_req_valid_o), 32'd0);
        tick();
        flush_i          = 1'b0;
        imem_req_ready_i = 1'b1;
        @(negedge clk);
        check("drain_valid", 32'(if_valid_o), 32'd0);
        check("drain_no_req", 32'(imem_req_valid_o), 32'd0);
        tick();
        @(negedge clk);
        check("post_drain_valid", 32'(if_valid_o), 32'd0);
        check("post_drain_req", 32'(imem_req_valid_o), 32'd1);
        check("post_drain_addr", imem_req_addr_o, 32'h100);
        tick();
        if_ready_i = 1'b1;
        wait_first_out("post_flush_first_pc", 32'h100, 15);

        // Reset mid-stream with requests in flight
        do_reset(32'h0);
        lat        = 3;
        if_ready_i = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check_all_zero("midrst_immediate");
        tick();
        do_reset(32'h200);
        if_ready_i = 1'b1;
        wait_first_out("midrst_first_pc", 32'h200, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
